// File: rtl/pipeline_ctrl_unit_pkg.sv
// Shared control-path types for the RV32I pipeline controller: opcodes, control enums,
// the per-stage control bundles and a small funct3-to-ALU-op helper.
package ctrl_pkg;

    localparam int unsigned CTRL_REG_ADDR_W = 5;
    localparam int unsigned CTRL_ALU_CTRL_W = 4;
    localparam int unsigned CTRL_IMM_SRC_W  = 3;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [CTRL_ALU_CTRL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [CTRL_IMM_SRC_W-1:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    typedef struct packed {
        logic                       reg_write;
        result_src_e                result_src;
        logic                       mem_write;
        logic [2:0]                 mem_size;
        logic                       jump;
        logic                       branch;
        logic [2:0]                 funct3;
        alu_op_e                    alu_ctrl;
        logic                       alu_src_a;
        logic                       alu_src_b;
        logic                       jalr_sel;
        logic [CTRL_REG_ADDR_W-1:0] rd;
        logic [CTRL_REG_ADDR_W-1:0] rs1;
        logic [CTRL_REG_ADDR_W-1:0] rs2;
    } ctrl_bundle_t;

    // Later stages only keep the fields they still act on.
    typedef struct packed {
        logic                       reg_write;
        result_src_e                result_src;
        logic                       mem_write;
        logic [2:0]                 mem_size;
        logic [CTRL_REG_ADDR_W-1:0] rd;
    } mem_bundle_t;

    typedef struct packed {
        logic                       reg_write;
        result_src_e                result_src;
        logic [CTRL_REG_ADDR_W-1:0] rd;
    } wb_bundle_t;

    function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_unit_decoder.sv
// Combinational RV32I decoder: instruction word to control bundle, immediate format and illegal flag.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t ctrl,
    output imm_src_e     imm_src,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    // Unused source fields stay 0 so the hazard logic needs no separate "used" masks.
    always_comb begin
        ctrl    = '0;
        imm_src = IMM_I;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.rd        = rd;
                ctrl.rs1       = rs1;
                ctrl.rs2       = rs2;
                ctrl.alu_ctrl  = alu_op_from_f3(f3, instr[30]);
                illegal        = !((f7 == 7'h00) ||
                                   ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.rd        = rd;
                ctrl.rs1       = rs1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_ctrl  = alu_op_from_f3(f3, instr[30] && (f3 == 3'b101));
                if (f3 == 3'b001)
                    illegal = (f7 != 7'h00);
                else if (f3 == 3'b101)
                    illegal = !((f7 == 7'h00) || (f7 == 7'h20));
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.rd         = rd;
                ctrl.rs1        = rs1;
                ctrl.result_src = RES_MEM;
                ctrl.mem_size   = f3;
                ctrl.alu_src_b  = 1'b1;
                ctrl.alu_ctrl   = ALU_ADD;
                illegal         = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.mem_size  = f3;
                ctrl.rs1       = rs1;
                ctrl.rs2       = rs2;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
                imm_src        = IMM_S;
                illegal        = (f3 > 3'b010);
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.funct3   = f3;
                ctrl.rs1      = rs1;
                ctrl.rs2      = rs2;
                ctrl.alu_ctrl = ALU_SUB;
                imm_src       = IMM_B;
                illegal       = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.rd         = rd;
                ctrl.result_src = RES_IMM;
                imm_src         = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.rd        = rd;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
                imm_src        = IMM_U;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.rd         = rd;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.rd         = rd;
                ctrl.rs1        = rs1;
                ctrl.jump       = 1'b1;
                ctrl.jalr_sel   = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.alu_ctrl   = ALU_ADD;
                ctrl.result_src = RES_PC4;
                illegal         = (f3 != 3'b000);
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            ctrl    = '0;
            imm_src = IMM_I;
        end
        if (ctrl.rd == '0)
            ctrl.reg_write = 1'b0;
    end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// RV32I pipeline control: E/M/W control-bundle registers, branch resolution in E,
// load-use stall/flush generation and forwarding selects.
module pipeline_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned IMM_SRC_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_d,
    input  logic                  zero_e,
    input  logic                  lt_e,
    input  logic                  ltu_e,
    output logic [IMM_SRC_W-1:0]  imm_src_d,
    output logic                  illegal_d,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
    output logic                  alu_src_a_e,
    output logic                  alu_src_b_e,
    output logic                  jalr_sel_e,
    output logic                  pc_src_e,
    output logic                  mem_write_m,
    output logic [2:0]            mem_size_m,
    output logic                  reg_write_m,
    output logic [REG_ADDR_W-1:0] rd_m,
    output logic                  reg_write_w,
    output logic [REG_ADDR_W-1:0] rd_w,
    output logic [1:0]            result_src_w,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            fwd_a_e,
    output logic [1:0]            fwd_b_e
);

    ctrl_bundle_t dec_d;
    ctrl_bundle_t bundle_e;
    mem_bundle_t  bundle_m;
    wb_bundle_t   bundle_w;
    imm_src_e     imm_src;
    logic         cond_e;
    logic         load_use;

    ctrl_decoder u_decoder (
        .instr   (instr_d),
        .ctrl    (dec_d),
        .imm_src (imm_src),
        .illegal (illegal_d)
    );

    assign imm_src_d = imm_src;

    always_comb begin
        cond_e = 1'b0;
        case (bundle_e.funct3)
            F3_BEQ:  cond_e = zero_e;
            F3_BNE:  cond_e = !zero_e;
            F3_BLT:  cond_e = lt_e;
            F3_BGE:  cond_e = !lt_e;
            F3_BLTU: cond_e = ltu_e;
            F3_BGEU: cond_e = !ltu_e;
            default: cond_e = 1'b0;
        endcase
    end

    assign pc_src_e = bundle_e.jump | (bundle_e.branch & cond_e);

    // Decoder zeroes rs1/rs2 when unused, so matching against a nonzero rd_e covers the masks.
    assign load_use = (bundle_e.result_src == RES_MEM) && (bundle_e.rd != '0) &&
                      ((bundle_e.rd == dec_d.rs1) || (bundle_e.rd == dec_d.rs2));

    assign stall_f = load_use;
    assign stall_d = load_use;
    assign flush_d = pc_src_e;
    assign flush_e = load_use | pc_src_e;

    function automatic logic [1:0] fwd_sel(input logic [CTRL_REG_ADDR_W-1:0] rs,
                                           input mem_bundle_t m, input wb_bundle_t w);
        logic [1:0] sel;
        if (m.reg_write && (m.rd != '0) && (m.rd == rs))
            sel = 2'b10;
        else if (w.reg_write && (w.rd != '0) && (w.rd == rs))
            sel = 2'b01;
        else
            sel = 2'b00;
        return sel;
    endfunction

    assign fwd_a_e = fwd_sel(bundle_e.rs1, bundle_m, bundle_w);
    assign fwd_b_e = fwd_sel(bundle_e.rs2, bundle_m, bundle_w);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bundle_e <= '0;
            bundle_m <= '0;
            bundle_w <= '0;
        end else begin
            bundle_e <= flush_e ? '0 : dec_d;

            bundle_m.reg_write  <= bundle_e.reg_write;
            bundle_m.result_src <= bundle_e.result_src;
            bundle_m.mem_write  <= bundle_e.mem_write;
            bundle_m.mem_size   <= bundle_e.mem_size;
            bundle_m.rd         <= bundle_e.rd;

            bundle_w.reg_write  <= bundle_m.reg_write;
            bundle_w.result_src <= bundle_m.result_src;
            bundle_w.rd         <= bundle_m.rd;
        end
    end

    assign alu_ctrl_e   = bundle_e.alu_ctrl;
    assign alu_src_a_e  = bundle_e.alu_src_a;
    assign alu_src_b_e  = bundle_e.alu_src_b;
    assign jalr_sel_e   = bundle_e.jalr_sel;
    assign mem_write_m  = bundle_m.mem_write;
    assign mem_size_m   = bundle_m.mem_size;
    assign reg_write_m  = bundle_m.reg_write;
    assign rd_m         = bundle_m.rd;
    assign reg_write_w  = bundle_w.reg_write;
    assign rd_w         = bundle_w.rd;
    assign result_src_w = bundle_w.result_src;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed bench for pipeline_ctrl_unit; the bench plays the datapath (holds instr_d while stalled).
module tb_pipeline_ctrl_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_d;
    logic        zero_e;
    logic        lt_e;
    logic        ltu_e;
    logic [2:0]  imm_src_d;
    logic        illegal_d;
    logic [3:0]  alu_ctrl_e;
    logic        alu_src_a_e;
    logic        alu_src_b_e;
    logic        jalr_sel_e;
    logic        pc_src_e;
    logic        mem_write_m;
    logic [2:0]  mem_size_m;
    logic        reg_write_m;
    logic [4:0]  rd_m;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [1:0]  result_src_w;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        flush_e;
    logic [1:0]  fwd_a_e;
    logic [1:0]  fwd_b_e;

    int unsigned passed;
    int unsigned total;

    pipeline_ctrl_unit #(
        .REG_ADDR_W (5),
        .ALU_CTRL_W (4),
        .IMM_SRC_W  (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_d      (instr_d),
        .zero_e       (zero_e),
        .lt_e         (lt_e),
        .ltu_e        (ltu_e),
        .imm_src_d    (imm_src_d),
        .illegal_d    (illegal_d),
        .alu_ctrl_e   (alu_ctrl_e),
        .alu_src_a_e  (alu_src_a_e),
        .alu_src_b_e  (alu_src_b_e),
        .jalr_sel_e   (jalr_sel_e),
        .pc_src_e     (pc_src_e),
        .mem_write_m  (mem_write_m),
        .mem_size_m   (mem_size_m),
        .reg_write_m  (reg_write_m),
        .rd_m         (rd_m),
        .reg_write_w  (reg_write_w),
        .rd_w         (rd_w),
        .result_src_w (result_src_w),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .fwd_a_e      (fwd_a_e),
        .fwd_b_e      (fwd_b_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, f3, 5'd0, 7'b1100011};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [2:0] f3;
        logic       z;
        logic       lt;
        logic       ltu;
        logic       take;
    } bvec_t;

    bvec_t bv[12];

    logic [31:0] NOP, ADD_X5, SUB_X6, ADD_X0, SUB_X6_X0, ADD_X5_X5, LW_X3, ADD_X4, ADD_X4_IND;
    logic [31:0] JAL_X1, JALR_X1, LUI_X7, AUIPC_X8, SW_X5, SRAI_X9;

    initial begin
        passed = 0;
        total  = 0;

        NOP        = enc_i(12'd0, 5'd0, 3'b000, 5'd0, 7'b0010011);
        ADD_X5     = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd5);
        SUB_X6     = enc_r(7'h20, 5'd1, 5'd5, 3'b000, 5'd6);
        ADD_X0     = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0);
        SUB_X6_X0  = enc_r(7'h20, 5'd1, 5'd0, 3'b000, 5'd6);
        ADD_X5_X5  = enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd5);
        LW_X3      = enc_i(12'd0, 5'd2, 3'b010, 5'd3, 7'b0000011);
        ADD_X4     = enc_r(7'h00, 5'd3, 5'd3, 3'b000, 5'd4);
        ADD_X4_IND = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd4);
        JAL_X1     = {20'h00100, 5'd1, 7'b1101111};
        JALR_X1    = enc_i(12'd0, 5'd5, 3'b000, 5'd1, 7'b1100111);
        LUI_X7     = {20'h12345, 5'd7, 7'b0110111};
        AUIPC_X8   = {20'h00010, 5'd8, 7'b0010111};
        SW_X5      = {7'd0, 5'd5, 5'd2, 3'b010, 5'd0, 7'b0100011};
        SRAI_X9    = enc_i({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd9, 7'b0010011);

        bv[0]  = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b1};
        bv[1]  = '{3'b000, 1'b0, 1'b1, 1'b1, 1'b0};
        bv[2]  = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b1};
        bv[3]  = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0};
        bv[4]  = '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1};
        bv[5]  = '{3'b100, 1'b0, 1'b0, 1'b1, 1'b0};
        bv[6]  = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b1};
        bv[7]  = '{3'b101, 1'b0, 1'b1, 1'b0, 1'b0};
        bv[8]  = '{3'b110, 1'b0, 1'b0, 1'b1, 1'b1};
        bv[9]  = '{3'b110, 1'b0, 1'b1, 1'b0, 1'b0};
        bv[10] = '{3'b111, 1'b1, 1'b1, 1'b0, 1'b1};
        bv[11] = '{3'b111, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset held for two edges with a valid add presented in D.
        rst_n   = 1'b0;
        instr_d = ADD_X5;
        zero_e  = 1'b0;
        lt_e    = 1'b0;
        ltu_e   = 1'b0;
        repeat (2) tick;
        chk("rst_alu_src_b_e", alu_src_b_e, 0);
        chk("rst_reg_write_m", reg_write_m, 0);
        chk("rst_reg_write_w", reg_write_w, 0);
        chk("rst_rd_m", rd_m, 0);
        chk("rst_pc_src_e", pc_src_e, 0);
        chk("rst_stall_f", stall_f, 0);

        rst_n = 1'b1;
        tick;
        instr_d = NOP;
        chk("lat1_reg_write_m", reg_write_m, 0);
        tick;
        chk("lat2_reg_write_m", reg_write_m, 1);
        chk("lat2_rd_m", rd_m, 5);
        chk("lat2_reg_write_w", reg_write_w, 0);
        tick;
        chk("lat3_reg_write_w", reg_write_w, 1);
        chk("lat3_rd_w", rd_w, 5);
        chk("lat3_result_src_w", result_src_w, 0);
        repeat (3) tick;
        chk("nop_reg_write_w", reg_write_w, 0);

        // Forwarding from M, from W, and never from x0.
        instr_d = ADD_X5;
        tick;
        instr_d = SUB_X6;
        tick;
        instr_d = NOP;
        chk("fwdM_a", fwd_a_e, 2'b10);
        chk("fwdM_b", fwd_b_e, 2'b00);
        chk("sub_alu_ctrl", alu_ctrl_e, 1);
        repeat (3) tick;

        instr_d = ADD_X5;
        tick;
        instr_d = NOP;
        tick;
        instr_d = SUB_X6;
        tick;
        instr_d = NOP;
        chk("fwdW_a", fwd_a_e, 2'b01);
        repeat (3) tick;

        instr_d = ADD_X0;
        tick;
        instr_d = SUB_X6_X0;
        tick;
        instr_d = NOP;
        chk("fwd_x0_a", fwd_a_e, 2'b00);
        chk("x0_reg_write_m", reg_write_m, 0);
        repeat (3) tick;

        instr_d = ADD_X5;
        tick;
        instr_d = ADD_X5_X5;
        tick;
        instr_d = SUB_X6;
        tick;
        instr_d = NOP;
        chk("fwd_prio_a", fwd_a_e, 2'b10);
        repeat (3) tick;

        // Load-use: one stall cycle, then W forwarding for both operands.
        instr_d = LW_X3;
        tick;
        instr_d = ADD_X4;
        #1;
        chk("lu_stall_f", stall_f, 1);
        chk("lu_stall_d", stall_d, 1);
        chk("lu_flush_e", flush_e, 1);
        chk("lu_flush_d", flush_d, 0);
        tick;
        chk("lu2_stall_f", stall_f, 0);
        chk("lu2_flush_e", flush_e, 0);
        chk("lu2_mem_size_m", mem_size_m, 3'b010);
        chk("lu2_mem_write_m", mem_write_m, 0);
        tick;
        instr_d = NOP;
        chk("lu_fwd_a", fwd_a_e, 2'b01);
        chk("lu_fwd_b", fwd_b_e, 2'b01);
        chk("lu_result_src_w", result_src_w, 2'b01);
        chk("lu_rd_w", rd_w, 3);
        repeat (3) tick;

        instr_d = LW_X3;
        tick;
        instr_d = ADD_X4_IND;
        #1;
        chk("no_lu_stall_f", stall_f, 0);
        tick;
        instr_d = NOP;
        repeat (3) tick;

        // All six branch conditions, taken and not taken.
        for (int i = 0; i < 12; i++) begin
            instr_d = enc_b(bv[i].f3, 5'd1, 5'd2);
            #1;
            chk($sformatf("br%0d_imm_src_d", i), imm_src_d, 3'b010);
            tick;
            instr_d = NOP;
            zero_e  = bv[i].z;
            lt_e    = bv[i].lt;
            ltu_e   = bv[i].ltu;
            #1;
            chk($sformatf("br%0d_pc_src_e", i), pc_src_e, bv[i].take);
            chk($sformatf("br%0d_flush_d", i), flush_d, bv[i].take);
            chk($sformatf("br%0d_flush_e", i), flush_e, bv[i].take);
            tick;
        end
        zero_e = 1'b0;
        lt_e   = 1'b1;
        ltu_e  = 1'b1;
        repeat (2) tick;

        // Illegal encodings decode to a bubble with no hazard side effects.
        instr_d = 32'h0000_0000;
        #1;
        chk("ill0_illegal_d", illegal_d, 1);
        chk("ill0_stall_f", stall_f, 0);
        tick;
        instr_d = NOP;
        chk("ill0_pc_src_e", pc_src_e, 0);
        chk("ill0_alu_src_b_e", alu_src_b_e, 0);
        chk("ill0_alu_ctrl_e", alu_ctrl_e, 0);
        tick;
        chk("ill0_reg_write_m", reg_write_m, 0);
        instr_d = enc_b(3'b010, 5'd1, 5'd2);
        #1;
        chk("illbr_illegal_d", illegal_d, 1);
        tick;
        instr_d = NOP;
        chk("illbr_pc_src_e", pc_src_e, 0);
        chk("illbr_flush_d", flush_d, 0);
        lt_e  = 1'b0;
        ltu_e = 1'b0;
        repeat (3) tick;

        // jal / jalr / lui / auipc / sw / srai
        instr_d = JAL_X1;
        #1;
        chk("jal_imm_src_d", imm_src_d, 3'b100);
        chk("jal_illegal_d", illegal_d, 0);
        tick;
        instr_d = NOP;
        chk("jal_pc_src_e", pc_src_e, 1);
        chk("jal_jalr_sel_e", jalr_sel_e, 0);
        chk("jal_flush_d", flush_d, 1);
        chk("jal_flush_e", flush_e, 1);
        repeat (2) tick;
        chk("jal_result_src_w", result_src_w, 2'b10);
        chk("jal_rd_w", rd_w, 1);
        repeat (3) tick;

        instr_d = JALR_X1;
        #1;
        chk("jalr_imm_src_d", imm_src_d, 3'b000);
        tick;
        instr_d = NOP;
        chk("jalr_pc_src_e", pc_src_e, 1);
        chk("jalr_jalr_sel_e", jalr_sel_e, 1);
        chk("jalr_alu_src_b_e", alu_src_b_e, 1);
        repeat (2) tick;
        chk("jalr_result_src_w", result_src_w, 2'b10);
        repeat (3) tick;

        instr_d = LUI_X7;
        #1;
        chk("lui_imm_src_d", imm_src_d, 3'b011);
        tick;
        instr_d = NOP;
        chk("lui_pc_src_e", pc_src_e, 0);
        repeat (2) tick;
        chk("lui_result_src_w", result_src_w, 2'b11);
        chk("lui_rd_w", rd_w, 7);
        chk("lui_reg_write_w", reg_write_w, 1);
        repeat (3) tick;

        instr_d = AUIPC_X8;
        tick;
        instr_d = NOP;
        chk("auipc_alu_src_a_e", alu_src_a_e, 1);
        chk("auipc_alu_src_b_e", alu_src_b_e, 1);
        chk("auipc_alu_ctrl_e", alu_ctrl_e, 0);
        repeat (3) tick;

        instr_d = SW_X5;
        #1;
        chk("sw_imm_src_d", imm_src_d, 3'b001);
        tick;
        instr_d = NOP;
        tick;
        chk("sw_mem_write_m", mem_write_m, 1);
        chk("sw_mem_size_m", mem_size_m, 3'b010);
        chk("sw_reg_write_m", reg_write_m, 0);
        repeat (3) tick;

        instr_d = SRAI_X9;
        #1;
        chk("srai_illegal_d", illegal_d, 0);
        tick;
        instr_d = NOP;
        chk("srai_alu_ctrl_e", alu_ctrl_e, 9);
        chk("srai_alu_src_b_e", alu_src_b_e, 1);
        repeat (3) tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
